memory_stage: RTL and testbench
===============================

// Module: memory_stage
// PURPOSE
//  Y86-64 pipeline memory stage: consumes the M pipeline register from execute, accesses
//  byte-addressed little-endian data memory, and drives the W register to writeback.
//  Exposes m_valM/m_stat combinationally for forwarding and hazard control, and a
//  mem_busy stall request when MEM_LAT > 0.
// PARAMETERS
//  MEM_BYTES  1024  data memory size in bytes; valid word address a iff a+7 < MEM_BYTES
//  MEM_LAT    0     extra wait cycles per memory access (0 = single-cycle)
// PORTS
//  clk       in   1   clock, rising edge
//  rst       in   1   synchronous, active-high reset
//  M_stat    in   [0:3] status, one-hot: 1000 AOK, 0100 HLT, 0010 ADR, 0001 INS
//  M_icode   in   4   instruction code
//  M_cnd     in   1   condition result from execute
//  M_valE    in   64  ALU result / address
//  M_valA    in   64  store data / ret-pop address
//  M_dstE    in   4   dest reg for valE (4'hF = none)
//  M_dstM    in   4   dest reg for valM (4'hF = none)
//  W_stall   in   1   hold W register
//  W_bubble  in   1   load nop bubble into W
//  m_stat    out  [0:3] combinational stage status
//  m_valM    out  64  combinational read data (forwarding)
//  mem_busy  out  1   access in progress; controller must hold M and upstream
//  W_stat, W_icode[3:0], W_valE[63:0], W_valM[63:0], W_dstE[3:0], W_dstM[3:0]  out  W register
// BEHAVIOUR
//  Address: icode 4,5,8,A -> M_valE; 9,B -> M_valA. Write (M_valA data): 4,8,A. Read: 5,9,B.
//  mem_op = read|write; dmem_error = mem_op & address invalid (incl. a+7 overflow of 64 bits).
//  m_stat = dmem_error ? 0010 : M_stat. m_valM = 8 bytes at addr (little-endian) when read,
//   not busy, no error; else 0.
//  Counter cnt (0..MEM_LAT): mem_busy = mem_op & (cnt != MEM_LAT). MEM_LAT=0 -> never busy.
//   Edge with mem_busy & ~W_stall: cnt++. Edge with access complete (~mem_busy) & ~W_stall: cnt<=0.
//  Write commits at the completing edge only, and only if M_stat==AOK, ~dmem_error, ~W_stall;
//   exactly one write per instruction. Reads have no side effect.
//  W update priority per edge: rst > W_stall (hold all) > W_bubble | mem_busy (load bubble)
//   > normal load: W_stat<=m_stat, W_icode<=M_icode, W_valE<=M_valE, W_valM<=m_valM,
//   W_dstE<=M_dstE, W_dstM<=M_dstM.
//  Bubble/reset value: W_stat=1000, W_icode=4'h1 (nop), W_valE=0, W_valM=0, W_dstE=W_dstM=4'hF.
//  Reset also clears cnt to 0; reset mid-access abandons it with no write. Memory contents
//   are not affected by rst; all bytes are zero at time zero.
//  M_cnd unused except as pass-through context; dstE gating is complete before this stage.
//  Same-address write then read in consecutive instructions: the read sees the new data.
// TESTING
//  rst=1 one edge -> W_icode=1, W_stat=1000, W_dstE=W_dstM=F, W_valE=W_valM=0, mem_busy=0.
//  rmmovq (icode 4, valE=0x10, valA=0x1122334455667788), then mrmovq valE=0x10 -> m_valM and
//   W_valM=0x1122334455667788; byte 0x10 = 0x88.
//  mrmovq valE=MEM_BYTES-4 -> m_stat=0010, W_stat=0010, W_valM=0; rmmovq to same address -> no write.
//  MEM_LAT=2, popq valA=0x20: mem_busy=1 for 2 cycles, W loads bubbles, third edge W_valM=mem[0x20].
//  W_stall=1 across a completing rmmovq -> W unchanged, no write; stall drops -> single write.
//  rmmovq with M_stat=0100 -> no memory write; W_stat=0100. W_bubble=1 with valid M -> W nop.

Source files
------------

// File: rtl/memory_stage.sv
// Y86-64 memory stage: byte-addressed little-endian data memory between the M and W
// pipeline registers, with an optional fixed access latency reported through mem_busy.
module memory_stage #(
   parameter int MEM_BYTES = 1024,
   parameter int MEM_LAT   = 0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [0:3]  M_stat,
   input  logic [3:0]  M_icode,
   input  logic        M_cnd,
   input  logic [63:0] M_valE,
   input  logic [63:0] M_valA,
   input  logic [3:0]  M_dstE,
   input  logic [3:0]  M_dstM,
   input  logic        W_stall,
   input  logic        W_bubble,
   output logic [0:3]  m_stat,
   output logic [63:0] m_valM,
   output logic        mem_busy,
   output logic [0:3]  W_stat,
   output logic [3:0]  W_icode,
   output logic [63:0] W_valE,
   output logic [63:0] W_valM,
   output logic [3:0]  W_dstE,
   output logic [3:0]  W_dstM
);

   localparam logic [0:3] STAT_AOK = 4'b1000;
   localparam logic [0:3] STAT_ADR = 4'b0010;
   localparam logic [3:0] ICODE_NOP = 4'h1;
   localparam logic [3:0] REG_NONE  = 4'hF;

   localparam int AW = (MEM_BYTES > 1) ? $clog2(MEM_BYTES) : 1;
   localparam int CW = (MEM_LAT > 0) ? $clog2(MEM_LAT + 1) : 1;

   logic [7:0]    mem [MEM_BYTES];
   logic [CW-1:0] cnt;

   logic          mem_rd;
   logic          mem_wr;
   logic          mem_op;
   logic [63:0]   addr;
   logic [64:0]   addr_end;
   logic          dmem_error;
   logic [AW-1:0] base;
   logic [63:0]   rd_data;
   logic          do_write;
   logic          unused_cnd;

   assign unused_cnd = M_cnd;

   always_comb begin
      mem_rd = 1'b0;
      mem_wr = 1'b0;
      case (M_icode)
         4'h4, 4'h8, 4'hA: mem_wr = 1'b1;
         4'h5, 4'h9, 4'hB: mem_rd = 1'b1;
         default: ;
      endcase
   end

   assign mem_op = mem_rd | mem_wr;
   // popq/ret address through valA (old %rsp); everything else through valE.
   assign addr = (M_icode == 4'h9 || M_icode == 4'hB) ? M_valA : M_valE;
   // 65-bit sum so a wrap past 2^64 is still seen as out of range.
   assign addr_end   = {1'b0, addr} + 65'd7;
   assign dmem_error = mem_op & (addr_end >= 65'(MEM_BYTES));
   assign base       = addr[AW-1:0];

   assign mem_busy = mem_op & (cnt != CW'(MEM_LAT));

   always_comb begin
      rd_data = '0;
      for (int i = 0; i < 8; i++) begin
         rd_data[8*i +: 8] = mem[base + AW'(i)];
      end
   end

   assign m_valM = (mem_rd & ~mem_busy & ~dmem_error) ? rd_data : 64'd0;
   assign m_stat = dmem_error ? STAT_ADR : M_stat;

   assign do_write = mem_wr & ~mem_busy & ~W_stall & ~rst & ~dmem_error & (M_stat == STAT_AOK);

   always_ff @(posedge clk) begin
      if (do_write) begin
         for (int i = 0; i < 8; i++) begin
            mem[base + AW'(i)] <= M_valA[8*i +: 8];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
      end else if (!W_stall) begin
         if (mem_busy) begin
            cnt <= cnt + CW'(1);
         end else begin
            cnt <= '0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         W_stat  <= STAT_AOK;
         W_icode <= ICODE_NOP;
         W_valE  <= '0;
         W_valM  <= '0;
         W_dstE  <= REG_NONE;
         W_dstM  <= REG_NONE;
      end else if (W_stall) begin
         W_stat  <= W_stat;
      end else if (W_bubble || mem_busy) begin
         W_stat  <= STAT_AOK;
         W_icode <= ICODE_NOP;
         W_valE  <= '0;
         W_valM  <= '0;
         W_dstE  <= REG_NONE;
         W_dstM  <= REG_NONE;
      end else begin
         W_stat  <= m_stat;
         W_icode <= M_icode;
         W_valE  <= M_valE;
         W_valM  <= m_valM;
         W_dstE  <= M_dstE;
         W_dstM  <= M_dstM;
      end
   end

endmodule

// File: tb/tb_memory_stage.sv
// Bench for memory_stage: directed scenarios on a single-cycle and a two-wait-cycle
// instance, plus a randomized run against a byte-array memory model.
module tb_memory_stage;

   localparam int MEM_BYTES = 1024;
   localparam logic [0:3] AOK = 4'b1000;
   localparam logic [0:3] HLT = 4'b0100;
   localparam logic [0:3] ADR = 4'b0010;
   localparam logic [0:3] INS = 4'b0001;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, M_cnd, W_stall, W_bubble;
   logic [0:3]  M_stat;
   logic [3:0]  M_icode, M_dstE, M_dstM;
   logic [63:0] M_valE, M_valA;
   logic [0:3]  m_stat, W_stat;
   logic [63:0] m_valM, W_valE, W_valM;
   logic        mem_busy;
   logic [3:0]  W_icode, W_dstE, W_dstM;

   logic [3:0]  l_icode;
   logic [63:0] l_valE, l_valA;
   logic [0:3]  l_m_stat, l_W_stat;
   logic [63:0] l_m_valM, l_W_valE, l_W_valM;
   logic        l_busy;
   logic [3:0]  l_W_icode, l_W_dstE, l_W_dstM;

   int vecs = 0;
   int errs = 0;

   logic [7:0] mdl [MEM_BYTES];

   memory_stage #(.MEM_BYTES(MEM_BYTES), .MEM_LAT(0)) u_dut0 (
      .clk(clk), .rst(rst), .M_stat(M_stat), .M_icode(M_icode), .M_cnd(M_cnd),
      .M_valE(M_valE), .M_valA(M_valA), .M_dstE(M_dstE), .M_dstM(M_dstM),
      .W_stall(W_stall), .W_bubble(W_bubble), .m_stat(m_stat), .m_valM(m_valM),
      .mem_busy(mem_busy), .W_stat(W_stat), .W_icode(W_icode), .W_valE(W_valE),
      .W_valM(W_valM), .W_dstE(W_dstE), .W_dstM(W_dstM));

   memory_stage #(.MEM_BYTES(MEM_BYTES), .MEM_LAT(2)) u_dut1 (
      .clk(clk), .rst(rst), .M_stat(M_stat), .M_icode(l_icode), .M_cnd(M_cnd),
      .M_valE(l_valE), .M_valA(l_valA), .M_dstE(M_dstE), .M_dstM(M_dstM),
      .W_stall(W_stall), .W_bubble(W_bubble), .m_stat(l_m_stat), .m_valM(l_m_valM),
      .mem_busy(l_busy), .W_stat(l_W_stat), .W_icode(l_W_icode), .W_valE(l_W_valE),
      .W_valM(l_W_valM), .W_dstE(l_W_dstE), .W_dstM(l_W_dstM));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_m(input logic [3:0] ic, input logic [63:0] ve, input logic [63:0] va,
                        input logic [0:3] st);
      M_icode = ic;
      M_valE  = ve;
      M_valA  = va;
      M_stat  = st;
      M_dstE  = 4'h3;
      M_dstM  = 4'h5;
   endtask

   task automatic test_reset();
      rst = 1'b1; W_stall = 1'b0; W_bubble = 1'b0; M_cnd = 1'b0;
      set_m(4'h5, 64'h10, 64'h0, INS);
      l_icode = 4'h0; l_valE = '0; l_valA = '0;
      tick();
      rst = 1'b0;
      vecs++; if (W_icode !== 4'h1) begin errs++; $display("FAIL rst_W_icode got=%h exp=1", W_icode); end
      vecs++; if (W_stat !== AOK) begin errs++; $display("FAIL rst_W_stat got=%b exp=1000", W_stat); end
      vecs++; if (W_dstE !== 4'hF || W_dstM !== 4'hF) begin errs++; $display("FAIL rst_W_dst got=%h/%h exp=f/f", W_dstE, W_dstM); end
      vecs++; if (W_valE !== 64'd0 || W_valM !== 64'd0) begin errs++; $display("FAIL rst_W_val got=%h/%h exp=0/0", W_valE, W_valM); end
      vecs++; if (mem_busy !== 1'b0) begin errs++; $display("FAIL rst_busy got=%b exp=0", mem_busy); end
      vecs++; if (l_W_icode !== 4'h1 || l_busy !== 1'b0) begin errs++; $display("FAIL rst_lat_dut got icode=%h busy=%b exp 1/0", l_W_icode, l_busy); end
   endtask

   task automatic test_store_load();
      set_m(4'h4, 64'h10, 64'h1122334455667788, AOK);
      #1;
      vecs++; if (m_valM !== 64'd0 || m_stat !== AOK) begin errs++; $display("FAIL st_comb got valM=%h stat=%b exp 0/1000", m_valM, m_stat); end
      tick();
      vecs++; if (W_icode !== 4'h4 || W_valE !== 64'h10) begin errs++; $display("FAIL st_W got icode=%h valE=%h exp 4/10", W_icode, W_valE); end
      set_m(4'h5, 64'h10, 64'h0, AOK);
      #1;
      vecs++; if (m_valM !== 64'h1122334455667788) begin errs++; $display("FAIL ld_m_valM got=%h exp=1122334455667788", m_valM); end
      tick();
      vecs++; if (W_valM !== 64'h1122334455667788 || W_dstM !== 4'h5) begin errs++; $display("FAIL ld_W got valM=%h dstM=%h exp 1122334455667788/5", W_valM, W_dstM); end
      set_m(4'h5, 64'h09, 64'h0, AOK);
      #1;
      vecs++; if (m_valM !== 64'h8800000000000000) begin errs++; $display("FAIL ld_byte10 got=%h exp=8800000000000000", m_valM); end
      set_m(4'h9, 64'h300, 64'h10, AOK);
      #1;
      vecs++; if (m_valM !== 64'h1122334455667788) begin errs++; $display("FAIL popq_addr got=%h exp=1122334455667788", m_valM); end
      tick();
   endtask

   task automatic test_boundary();
      set_m(4'h5, 64'(MEM_BYTES - 4), 64'h0, AOK);
      #1;
      vecs++; if (m_stat !== ADR || m_valM !== 64'd0) begin errs++; $display("FAIL bnd_comb got stat=%b valM=%h exp 0010/0", m_stat, m_valM); end
      tick();
      vecs++; if (W_stat !== ADR || W_valM !== 64'd0) begin errs++; $display("FAIL bnd_W got stat=%b valM=%h exp 0010/0", W_stat, W_valM); end
      set_m(4'h4, 64'(MEM_BYTES - 4), 64'hDEADBEEFCAFEF00D, AOK);
      tick();
      set_m(4'h5, 64'(MEM_BYTES - 8), 64'h0, AOK);
      #1;
      vecs++; if (m_stat !== AOK || m_valM !== 64'd0) begin errs++; $display("FAIL bnd_nowrite got stat=%b valM=%h exp 1000/0", m_stat, m_valM); end
      set_m(4'h5, 64'hFFFFFFFFFFFFFFFC, 64'h0, AOK);
      #1;
      vecs++; if (m_stat !== ADR) begin errs++; $display("FAIL bnd_wrap got=%b exp=0010", m_stat); end
      set_m(4'hB, 64'h0, 64'hFFFFFFFFFFFFFFF9, HLT);
      #1;
      vecs++; if (m_stat !== ADR) begin errs++; $display("FAIL bnd_ret got=%b exp=0010", m_stat); end
      set_m(4'h6, 64'hFFFFFFFFFFFFFFFC, 64'h0, AOK);
      #1;
      vecs++; if (m_stat !== AOK || m_valM !== 64'd0) begin errs++; $display("FAIL bnd_nonmem got stat=%b valM=%h exp 1000/0", m_stat, m_valM); end
      tick();
   endtask

   task automatic test_stall();
      set_m(4'h1, 64'h0, 64'h0, AOK);
      tick();
      W_stall = 1'b1;
      set_m(4'h4, 64'h30, 64'hA5A5000011112222, AOK);
      tick();
      tick();
      vecs++; if (W_icode !== 4'h1 || W_valE !== 64'd0) begin errs++; $display("FAIL stall_hold got icode=%h valE=%h exp 1/0", W_icode, W_valE); end
      set_m(4'h5, 64'h30, 64'h0, AOK);
      #1;
      vecs++; if (m_valM !== 64'd0) begin errs++; $display("FAIL stall_nowrite got=%h exp=0", m_valM); end
      set_m(4'h4, 64'h30, 64'hA5A5000011112222, AOK);
      W_stall = 1'b0;
      tick();
      vecs++; if (W_icode !== 4'h4 || W_valE !== 64'h30) begin errs++; $display("FAIL stall_release got icode=%h valE=%h exp 4/30", W_icode, W_valE); end
      set_m(4'h5, 64'h30, 64'h0, AOK);
      #1;
      vecs++; if (m_valM !== 64'hA5A5000011112222) begin errs++; $display("FAIL stall_write got=%h exp=a5a5000011112222", m_valM); end
      tick();
   endtask

   task automatic test_status();
      set_m(4'h4, 64'h50, 64'h0123456789ABCDEF, HLT);
      #1;
      vecs++; if (m_stat !== HLT) begin errs++; $display("FAIL hlt_m_stat got=%b exp=0100", m_stat); end
      tick();
      vecs++; if (W_stat !== HLT) begin errs++; $display("FAIL hlt_W_stat got=%b exp=0100", W_stat); end
      set_m(4'h5, 64'h50, 64'h0, AOK);
      #1;
      vecs++; if (m_valM !== 64'd0) begin errs++; $display("FAIL hlt_nowrite got=%h exp=0", m_valM); end
      set_m(4'h5, 64'h10, 64'h0, AOK);
      W_bubble = 1'b1;
      tick();
      W_bubble = 1'b0;
      vecs++; if (W_icode !== 4'h1 || W_valM !== 64'd0 || W_dstM !== 4'hF || W_stat !== AOK) begin
         errs++; $display("FAIL bubble got icode=%h valM=%h dstM=%h stat=%b exp 1/0/f/1000", W_icode, W_valM, W_dstM, W_stat);
      end
   endtask

   task automatic test_latency();
      set_m(4'h1, 64'h0, 64'h0, AOK);
      l_icode = 4'h4; l_valE = 64'h20; l_valA = 64'hCAFEF00D12345678;
      #1;
      vecs++; if (l_busy !== 1'b1) begin errs++; $display("FAIL lat_busy0 got=%b exp=1", l_busy); end
      tick();
      vecs++; if (l_W_icode !== 4'h1 || l_busy !== 1'b1) begin errs++; $display("FAIL lat_edge1 got icode=%h busy=%b exp 1/1", l_W_icode, l_busy); end
      tick();
      vecs++; if (l_W_icode !== 4'h1 || l_busy !== 1'b0) begin errs++; $display("FAIL lat_edge2 got icode=%h busy=%b exp 1/0", l_W_icode, l_busy); end
      tick();
      vecs++; if (l_W_icode !== 4'h4 || l_W_valE !== 64'h20) begin errs++; $display("FAIL lat_edge3 got icode=%h valE=%h exp 4/20", l_W_icode, l_W_valE); end
      l_icode = 4'hB; l_valE = 64'h28; l_valA = 64'h20;
      #1;
      vecs++; if (l_busy !== 1'b1 || l_m_valM !== 64'd0) begin errs++; $display("FAIL pop_busy got busy=%b valM=%h exp 1/0", l_busy, l_m_valM); end
      tick();
      tick();
      vecs++; if (l_m_valM !== 64'hCAFEF00D12345678) begin errs++; $display("FAIL pop_comb got=%h exp=cafef00d12345678", l_m_valM); end
      tick();
      vecs++; if (l_W_valM !== 64'hCAFEF00D12345678 || l_W_icode !== 4'hB) begin errs++; $display("FAIL pop_W got valM=%h icode=%h exp cafef00d12345678/b", l_W_valM, l_W_icode); end
      l_icode = 4'h4; l_valE = 64'h40; l_valA = 64'h7777666655554444;
      tick();
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      vecs++; if (l_W_icode !== 4'h1) begin errs++; $display("FAIL rst_mid got icode=%h exp=1", l_W_icode); end
      l_icode = 4'h5;
      #1;
      vecs++; if (l_busy !== 1'b1) begin errs++; $display("FAIL rst_mid_busy got=%b exp=1", l_busy); end
      tick();
      tick();
      vecs++; if (l_m_valM !== 64'd0 || l_busy !== 1'b0) begin errs++; $display("FAIL rst_mid_nowrite got valM=%h busy=%b exp 0/0", l_m_valM, l_busy); end
      tick();
      l_icode = 4'h0;
   endtask

   task automatic test_random();
      logic [3:0]  ic, dE, dM, ew_icode, ew_dstE, ew_dstM;
      logic [63:0] a, ve, va, exp_valM, ew_valE, ew_valM;
      logic [0:3]  st, exp_stat, ew_stat;
      logic        rd, wr, err, stl, bub;
      logic [3:0]  mem_ops [6] = '{4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB};
      logic [0:3]  bad_st [3] = '{HLT, ADR, INS};
      int          r;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      ew_stat = AOK; ew_icode = 4'h1; ew_valE = '0; ew_valM = '0; ew_dstE = 4'hF; ew_dstM = 4'hF;
      for (int n = 0; n < 300; n++) begin
         ic = ($urandom_range(0, 3) != 0) ? mem_ops[$urandom_range(0, 5)] : 4'($urandom_range(0, 15));
         r = $urandom_range(0, 9);
         if (r <= 6)      a = 64'h100 + 64'($urandom_range(0, 'h1F8));
         else if (r == 7) a = 64'(MEM_BYTES - $urandom_range(1, 7));
         else if (r == 8) a = {32'hFFFFFFFF, 32'($urandom)};
         else             a = 64'(MEM_BYTES - 8);
         rd = ic inside {4'h5, 4'h9, 4'hB};
         wr = ic inside {4'h4, 4'h8, 4'hA};
         if (ic == 4'h9 || ic == 4'hB) begin va = a; ve = {32'($urandom), 32'($urandom)}; end
         else begin ve = a; va = {32'($urandom), 32'($urandom)}; end
         st  = ($urandom_range(0, 7) == 0) ? bad_st[$urandom_range(0, 2)] : AOK;
         stl = ($urandom_range(0, 7) == 0);
         bub = ($urandom_range(0, 7) == 0);
         dE = 4'($urandom_range(0, 15)); dM = 4'($urandom_range(0, 15));
         M_icode = ic; M_valE = ve; M_valA = va; M_stat = st; M_dstE = dE; M_dstM = dM;
         M_cnd = 1'($urandom_range(0, 1)); W_stall = stl; W_bubble = bub;
         err = (rd || wr) && (a > 64'(MEM_BYTES - 8));
         exp_stat = err ? ADR : st;
         exp_valM = '0;
         if (rd && !err) for (int k = 0; k < 8; k++) exp_valM = exp_valM | (64'(mdl[32'(a) + k]) << (8 * k));
         #1;
         vecs++; if (m_stat !== exp_stat) begin errs++; $display("FAIL rnd_m_stat n=%0d got=%b exp=%b", n, m_stat, exp_stat); end
         vecs++; if (m_valM !== exp_valM) begin errs++; $display("FAIL rnd_m_valM n=%0d got=%h exp=%h", n, m_valM, exp_valM); end
         vecs++; if (mem_busy !== 1'b0) begin errs++; $display("FAIL rnd_busy n=%0d got=%b exp=0", n, mem_busy); end
         if (!stl) begin
            if (bub) begin
               ew_stat = AOK; ew_icode = 4'h1; ew_valE = '0; ew_valM = '0; ew_dstE = 4'hF; ew_dstM = 4'hF;
            end else begin
               ew_stat = exp_stat; ew_icode = ic; ew_valE = ve; ew_valM = exp_valM; ew_dstE = dE; ew_dstM = dM;
            end
            if (wr && !err && st == AOK) for (int k = 0; k < 8; k++) mdl[32'(a) + k] = va[8*k +: 8];
         end
         tick();
         vecs++; if (W_stat !== ew_stat || W_icode !== ew_icode) begin errs++; $display("FAIL rnd_W_stat_icode n=%0d got=%b/%h exp=%b/%h", n, W_stat, W_icode, ew_stat, ew_icode); end
         vecs++; if (W_valE !== ew_valE) begin errs++; $display("FAIL rnd_W_valE n=%0d got=%h exp=%h", n, W_valE, ew_valE); end
         vecs++; if (W_valM !== ew_valM) begin errs++; $display("FAIL rnd_W_valM n=%0d got=%h exp=%h", n, W_valM, ew_valM); end
         vecs++; if (W_dstE !== ew_dstE || W_dstM !== ew_dstM) begin errs++; $display("FAIL rnd_W_dst n=%0d got=%h/%h exp=%h/%h", n, W_dstE, W_dstM, ew_dstE, ew_dstM); end
      end
      W_stall = 1'b0;
      W_bubble = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < MEM_BYTES; i++) mdl[i] = 8'h00;
      test_reset();
      test_store_load();
      test_boundary();
      test_stall();
      test_status();
      test_latency();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
